mxint8_block_deserializer: RTL and testbench
============================================

Name: mxint8_block_deserializer

Overview:
- Upstream stage of the MXINT8 element-wise ALU ops (negate, add, etc.).
- Accepts a stream of MXINT8 elements LANES at a time, with the shared E8M0 scale.
- Assembles one full block of BLOCK_SIZE elements plus its scale, then presents it as a single-cycle-wide block on a valid/ready interface.
- Single buffer with same-cycle drain/refill, so back-to-back blocks stream with no bubble.

Parameters:
- BLOCK_SIZE, 32, elements per MX block; must be a multiple of LANES.
- ELEMENT_WIDTH, 8, bits per MXINT8 element (two's complement).
- SCALE_WIDTH, 8, bits of the shared E8M0 scale.
- LANES, 4, elements accepted per input beat; BEATS = BLOCK_SIZE/LANES.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block accepts the input beat this cycle.
- i_elements  input  [0:LANES-1][ELEMENT_WIDTH-1:0]  beat elements; lane 0 = lowest element index.
- i_scale  input  SCALE_WIDTH  shared scale; sampled only on beat 0 of a block.
- i_last  input  1  marks the final beat of a block.
- o_valid  output  1  full block available.
- i_ready  input  1  downstream accepts the block.
- o_elements  output  [0:BLOCK_SIZE-1][ELEMENT_WIDTH-1:0]  assembled block, element 0 at index 0.
- o_scale  output  SCALE_WIDTH  scale of the presented block.
- o_len_err  output  1  one-cycle pulse on an i_last / beat-count mismatch.

Behaviour:
- Input transfer occurs when i_valid && o_ready. Output transfer occurs when o_valid && i_ready.
- States:
  - FILL: collecting beats; o_valid=0; o_ready=1.
  - FULL: block held; o_valid=1; o_ready=i_ready (combinational passthrough).
- Beat counter cnt runs 0..BEATS-1. On a transfer, lane j is written to element cnt*LANES+j, then cnt increments.
- On the transfer with cnt==0, i_scale is latched into the held scale.
- Transfer with cnt==BEATS-1: cnt wraps to 0 and the state goes to FULL. The block is visible on o_elements/o_scale with o_valid=1 the next cycle (latency 1 cycle after the final beat).
- FULL with an output transfer and no input transfer: go to FILL, cnt=0.
- FULL with output and input transfers in the same cycle:
  - The beat is written as beat 0 of the next block and its scale is latched; go to FILL with cnt=1.
  - The outgoing block is the pre-edge register contents.
- o_elements and o_scale are stable while o_valid=1 && !i_ready.
- Element locations not yet overwritten hold stale data. Only the contents present while o_valid=1 are defined.
- i_last rules:
  - i_last=1 on a transfer with cnt<BEATS-1: the partial block is discarded, cnt=0, state stays FILL, o_len_err=1 next cycle.
  - i_last=0 on the transfer with cnt==BEATS-1: the block completes normally and o_len_err=1 next cycle.
  - i_last=1 on the final beat: no error.
- If BEATS==1, every accepted beat completes a block.
- i_elements and i_scale are ignored when no input transfer occurs. i_scale is ignored on beats 1..BEATS-1.
- No arithmetic is performed: elements and scale pass bit-exact, including scale 0xFF (NaN), which is passed unchanged.
- Reset (async assert, released synchronously by the system):
  - state=FILL, cnt=0, o_valid=0, o_len_err=0.
  - o_scale=0 and all o_elements=0.
  - o_ready=1 in the first cycle after reset release.
- Reset mid-fill or while FULL: the held block is lost and no o_valid is produced for it.

Test Plan:
- Reset then 8 beats (defaults), lanes = k*4+j values 0x00..0x1F, i_scale=0x7F on beat 0 and 0x11 on other beats, i_last on beat 7, i_ready=1 -> o_valid high one cycle after beat 7; o_elements[n]=n; o_scale=0x7F; o_len_err never pulses.
- Backpressure: block complete, i_ready=0 for 5 cycles with i_valid=1 -> o_ready=0, outputs stable for 5 cycles; then i_ready=1 -> beat accepted the same cycle; next block's element 0..3 come from that beat.
- Streaming 3 blocks with i_valid=i_ready=1 continuously -> o_valid pulses every 8 cycles, no bubble; scales 0x01, 0x80, 0xFF appear in order.
- i_last asserted on beat 3 -> no o_valid; o_len_err=1 for exactly one cycle; the next 8 beats form a correct block with the scale from its own beat 0.
- i_last missing on beat 7 -> block delivered with correct data; o_len_err pulses once, one cycle after beat 7.
- Assert i_rst_n=0 asynchronously after beat 5, then release -> o_valid=0, o_elements all 0x00; the following full 8-beat block is assembled from cnt=0.

Source files
------------

// File: rtl/mxint8_block_deserializer.sv
// Gathers LANES-wide MXINT8 beats into one BLOCK_SIZE block plus its shared E8M0 scale.
// A single buffer drains and refills in the same cycle, so back-to-back blocks stream with no bubble.
module mxint8_block_deserializer #(
    parameter int BLOCK_SIZE    = 32,
    parameter int ELEMENT_WIDTH = 8,
    parameter int SCALE_WIDTH   = 8,
    parameter int LANES         = 4
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst_n,
    input  logic                                       i_valid,
    output logic                                       o_ready,
    input  logic [0:LANES-1][ELEMENT_WIDTH-1:0]        i_elements,
    input  logic [SCALE_WIDTH-1:0]                     i_scale,
    input  logic                                       i_last,
    output logic                                       o_valid,
    input  logic                                       i_ready,
    output logic [0:BLOCK_SIZE-1][ELEMENT_WIDTH-1:0]   o_elements,
    output logic [SCALE_WIDTH-1:0]                     o_scale,
    output logic                                       o_len_err
);

    localparam int BEATS = BLOCK_SIZE / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic {FILL, FULL} state_e;

    state_e                                    state_q, state_d;
    logic [CW-1:0]                             cnt_q, cnt_d;
    logic [0:BLOCK_SIZE-1][ELEMENT_WIDTH-1:0]  elems_q, elems_d;
    logic [SCALE_WIDTH-1:0]                    scale_q, scale_d;
    logic                                      len_err_q, len_err_d;
    logic                                      in_xfer, out_xfer;

    assign o_valid    = (state_q == FULL);
    assign o_ready    = (state_q == FILL) ? 1'b1 : i_ready;
    assign in_xfer    = i_valid && o_ready;
    assign out_xfer   = o_valid && i_ready;
    assign o_elements = elems_q;
    assign o_scale    = scale_q;
    assign o_len_err  = len_err_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        elems_d   = elems_q;
        scale_d   = scale_q;
        len_err_d = 1'b0;

        // Draining first lets an accepted beat below override it as beat 0 of the next block.
        if (out_xfer) begin
            state_d = FILL;
            cnt_d   = '0;
        end

        if (in_xfer) begin
            for (int j = 0; j < LANES; j++)
                elems_d[int'(cnt_q) * LANES + j] = i_elements[j];
            if (cnt_q == '0)
                scale_d = i_scale;
            if (cnt_q == LAST_CNT) begin
                cnt_d     = '0;
                state_d   = FULL;
                len_err_d = !i_last;
            end else if (i_last) begin
                // Short block: drop what was gathered and restart on the next beat.
                cnt_d     = '0;
                len_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= FILL;
            cnt_q     <= '0;
            elems_q   <= '0;
            scale_q   <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            elems_q   <= elems_d;
            scale_q   <= scale_d;
            len_err_q <= len_err_d;
        end
    end

endmodule

// File: tb/tb_mxint8_block_deserializer.sv
// Directed bench for mxint8_block_deserializer at default parameters (32 elements, 4 lanes, 8 beats).
module tb_mxint8_block_deserializer;

    typedef logic [0:31][7:0] blk_t;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [0:3][7:0]  i_elements;
    logic [7:0]       i_scale;
    logic             i_last;
    logic             o_valid;
    logic             i_ready;
    blk_t             o_elements;
    logic [7:0]       o_scale;
    logic             o_len_err;

    int checks = 0;
    int errors = 0;

    mxint8_block_deserializer dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_elements (i_elements),
        .i_scale    (i_scale),
        .i_last     (i_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_elements (o_elements),
        .o_scale    (o_scale),
        .o_len_err  (o_len_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic blk_t blk(input logic [7:0] start);
        blk_t b;
        for (int n = 0; n < 32; n++) b[n] = start + 8'(n);
        return b;
    endfunction

    // Drive beat k of a block whose element n = start+n, then step past one rising edge.
    task automatic beat(input logic [7:0] start, input int k, input logic [7:0] sc, input logic last);
        i_valid = 1'b1;
        for (int j = 0; j < 4; j++) i_elements[j] = start + 8'(k * 4 + j);
        i_scale = sc;
        i_last  = last;
        @(posedge i_clk); #1;
    endtask

    task automatic idle_cycle();
        i_valid = 1'b0;
        i_last  = 1'b0;
        @(posedge i_clk); #1;
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_elements = '0; i_scale = '0; i_last = 1'b0; i_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_elements", o_elements, '0);
        check("rst_o_scale", o_scale, 8'h00);
        check("rst_o_len_err", o_len_err, 1'b0);
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("post_rst_o_ready", o_ready, 1'b1);

        // Basic block: scale comes only from beat 0.
        for (int k = 0; k < 8; k++) begin
            beat(8'h00, k, (k == 0) ? 8'h7F : 8'h11, k == 7);
            check("basic_len_err", o_len_err, 1'b0);
            check("basic_o_valid", o_valid, k == 7);
        end
        i_valid = 1'b0;
        check("basic_elements", o_elements, blk(8'h00));
        check("basic_scale", o_scale, 8'h7F);
        idle_cycle();
        check("basic_drained", o_valid, 1'b0);

        // Backpressure: held block stays stable while a beat waits.
        i_ready = 1'b0;
        for (int k = 0; k < 8; k++) beat(8'h20, k, (k == 0) ? 8'h22 : 8'h23, k == 7);
        i_valid = 1'b1;
        for (int j = 0; j < 4; j++) i_elements[j] = 8'h40 + 8'(j);
        i_scale = 8'h33;
        i_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("bp_o_ready", o_ready, 1'b0);
            check("bp_o_valid", o_valid, 1'b1);
            check("bp_elements", o_elements, blk(8'h20));
            check("bp_scale", o_scale, 8'h22);
            @(posedge i_clk); #1;
        end
        i_ready = 1'b1;
        #1;
        check("bp_release_o_ready", o_ready, 1'b1);
        @(posedge i_clk); #1;
        check("bp_after_swap_valid", o_valid, 1'b0);
        for (int k = 1; k < 8; k++) beat(8'h40, k, 8'h44, k == 7);
        i_valid = 1'b0;
        check("bp_next_valid", o_valid, 1'b1);
        check("bp_next_elements", o_elements, blk(8'h40));
        check("bp_next_scale", o_scale, 8'h33);
        idle_cycle();

        // Streaming three blocks with no bubble.
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 8; k++) begin
                beat(8'h60 + 8'(b * 32), k, (k != 0) ? 8'h5A : (b == 0) ? 8'h01 : (b == 1) ? 8'h80 : 8'hFF, k == 7);
                check("stream_o_valid", o_valid, k == 7);
            end
            check("stream_elements", o_elements, blk(8'h60 + 8'(b * 32)));
            check("stream_scale", o_scale, (b == 0) ? 8'h01 : (b == 1) ? 8'h80 : 8'hFF);
        end
        idle_cycle();
        check("stream_drained", o_valid, 1'b0);

        // Early i_last on beat 3: block dropped, one-cycle error pulse.
        for (int k = 0; k < 4; k++) beat(8'hC0, k, 8'h55, k == 3);
        check("short_o_valid", o_valid, 1'b0);
        check("short_len_err", o_len_err, 1'b1);
        idle_cycle();
        check("short_len_err_clr", o_len_err, 1'b0);
        check("short_o_valid2", o_valid, 1'b0);
        for (int k = 0; k < 8; k++) beat(8'hE0, k, (k == 0) ? 8'h66 : 8'h55, k == 7);
        i_valid = 1'b0;
        check("short_next_valid", o_valid, 1'b1);
        check("short_next_elements", o_elements, blk(8'hE0));
        check("short_next_scale", o_scale, 8'h66);
        check("short_next_len_err", o_len_err, 1'b0);
        idle_cycle();

        // Missing i_last on beat 7: block delivered, error pulses once.
        for (int k = 0; k < 8; k++) beat(8'h10, k, (k == 0) ? 8'h99 : 8'h00, 1'b0);
        i_valid = 1'b0;
        check("nolast_o_valid", o_valid, 1'b1);
        check("nolast_len_err", o_len_err, 1'b1);
        check("nolast_elements", o_elements, blk(8'h10));
        check("nolast_scale", o_scale, 8'h99);
        idle_cycle();
        check("nolast_len_err_clr", o_len_err, 1'b0);
        check("nolast_drained", o_valid, 1'b0);

        // Async reset after beat 5, then a full block from cnt 0.
        for (int k = 0; k < 6; k++) beat(8'h30, k, 8'h12, 1'b0);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("midrst_o_valid", o_valid, 1'b0);
        check("midrst_elements", o_elements, '0);
        check("midrst_scale", o_scale, 8'h00);
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("midrst_o_ready", o_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            beat(8'h50, k, (k == 0) ? 8'h21 : 8'h34, k == 7);
            check("midrst_fill_valid", o_valid, k == 7);
        end
        i_valid = 1'b0;
        check("midrst_elements2", o_elements, blk(8'h50));
        check("midrst_scale2", o_scale, 8'h21);
        check("midrst_len_err", o_len_err, 1'b0);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
